// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - framed serial receiver with one-entry valid/ready output buffer
module serial_frame_rx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_in,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, DATA, STOP, HUNT} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [WIDTH-1:0] shreg, shreg_nx;
   logic             word_done;
   logic             stop_bad;
   logic             load;
   logic             drop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         shreg <= shreg_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      shreg_nx  = shreg;
      word_done = 1'b0;
      stop_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (s_in) begin
               state_nx = DATA;
               cnt_nx   = '0;
            end
         end
         DATA: begin
            shreg_nx = {shreg[WIDTH-2:0], s_in};
            if (cnt == LAST_BIT) begin
               state_nx = STOP;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (s_in) begin
               stop_bad = 1'b1;
               state_nx = HUNT;
            end else begin
               word_done = 1'b1;
               state_nx  = IDLE;
            end
         end
         HUNT: begin
            // A stuck-high line must drop to 0 before another start bit counts
            if (!s_in) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Space exists if the buffer is empty or being drained on this same edge
   assign load = word_done && (!m_valid || m_ready);
   assign drop = word_done && m_valid && !m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data    <= '0;
         m_valid   <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= drop;
         if (load) begin
            m_data  <= shreg;
            m_valid <= 1'b1;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - directed self-checking bench for serial_frame_rx
module tb_serial_frame_rx;

   logic       clk;
   logic       rst_n;
   logic       s_in;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int tests;
   int failed;
   int pulses;

   serial_frame_rx #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_in      (s_in),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one serial bit, let the next rising edge sample it, settle 1 ns
   task automatic step(input logic b);
      s_in = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_data(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) step(d[i]);
   endtask

   task automatic send_frame(input logic [7:0] d);
      step(1'b1);
      send_data(d);
      step(1'b0);
   endtask

   initial begin
      tests   = 0;
      failed  = 0;
      rst_n   = 1'b0;
      s_in    = 1'b0;
      m_ready = 1'b0;
      #12;
      check("rst_m_data", 32'(m_data), 32'h00);
      check("rst_m_valid", 32'(m_valid), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;

      // Idle low, then stuck high: one frame_err, then parked in HUNT
      for (int i = 0; i < 40; i++) step(1'b0);
      check("idle_busy", 32'(busy), 32'h0);
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         step(1'b1);
         if (i == 9) check("stuck_err_edge", 32'(frame_err), 32'h1);
         if (frame_err) pulses++;
      end
      check("stuck_err_count", 32'(pulses), 32'd1);
      check("stuck_busy_hunt", 32'(busy), 32'h1);
      check("stuck_m_valid", 32'(m_valid), 32'h0);
      step(1'b0);
      check("hunt_exit_busy", 32'(busy), 32'h0);

      // 0xA5 with consumer ready
      m_ready = 1'b1;
      send_frame(8'hA5);
      check("a5_valid", 32'(m_valid), 32'h1);
      check("a5_data", 32'(m_data), 32'hA5);
      check("a5_ferr", 32'(frame_err), 32'h0);
      step(1'b0);
      check("a5_accepted", 32'(m_valid), 32'h0);
      check("a5_data_held", 32'(m_data), 32'hA5);

      // Back-to-back 0x3C, 0x81 with consumer stalled: overrun on the second
      m_ready = 1'b0;
      send_frame(8'h3C);
      check("3c_valid", 32'(m_valid), 32'h1);
      check("3c_data", 32'(m_data), 32'h3C);
      send_frame(8'h81);
      check("81_overrun", 32'(overrun), 32'h1);
      check("81_ferr_excl", 32'(frame_err), 32'h0);
      check("81_data_kept", 32'(m_data), 32'h3C);
      check("81_valid", 32'(m_valid), 32'h1);
      step(1'b0);
      check("overrun_pulse_end", 32'(overrun), 32'h0);
      check("overrun_data_still", 32'(m_data), 32'h3C);

      // Accept on the very edge the new stop bit arrives: no overrun
      step(1'b1);
      send_data(8'h81);
      m_ready = 1'b1;
      step(1'b0);
      check("same_edge_data", 32'(m_data), 32'h81);
      check("same_edge_valid", 32'(m_valid), 32'h1);
      check("same_edge_overrun", 32'(overrun), 32'h0);
      m_ready = 1'b0;

      // Async reset mid-frame after 4 data bits of 0xF0
      step(1'b1);
      for (int i = 0; i < 4; i++) step(1'b1);
      check("pre_rst_busy", 32'(busy), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_m_data", 32'(m_data), 32'h00);
      check("arst_m_valid", 32'(m_valid), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      check("arst_overrun", 32'(overrun), 32'h0);
      check("arst_ferr", 32'(frame_err), 32'h0);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step(1'b0);
      check("aborted_ignored_valid", 32'(m_valid), 32'h0);
      check("aborted_ignored_busy", 32'(busy), 32'h0);
      send_frame(8'h5A);
      check("5a_data", 32'(m_data), 32'h5A);
      check("5a_valid", 32'(m_valid), 32'h1);

      // Bad stop on 0x12, a single 0 leaves HUNT, then 0x34
      m_ready = 1'b1;
      step(1'b1);
      send_data(8'h12);
      step(1'b1);
      check("12_ferr", 32'(frame_err), 32'h1);
      check("12_overrun_excl", 32'(overrun), 32'h0);
      check("12_not_loaded", 32'(m_data), 32'h5A);
      step(1'b0);
      check("12_ferr_end", 32'(frame_err), 32'h0);
      check("12_hunt_exit", 32'(busy), 32'h0);
      send_frame(8'h34);
      check("34_data", 32'(m_data), 32'h34);
      check("34_valid", 32'(m_valid), 32'h1);
      step(1'b0);
      check("34_accepted", 32'(m_valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream consumer of the serial shift-register chain. Samples the single-bit serial stream `s_in` every `clk` rising edge and frames it as: start bit '1', then WIDTH data bits MSB first, then stop bit '0'.
- Delivers each completed word through a one-entry valid/ready output buffer.
- Flags framing errors and buffer overruns.
- Idle line level is '0'.

Parameters:
- WIDTH, 8, data bits per frame. Legal range is WIDTH >= 2.
- CNT_W, $clog2(WIDTH), width of the internal bit counter. Derived; not overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_in  input  1  serial data. Synchronous to clk; one bit per cycle.
- m_data  output  WIDTH  received word. Valid only while m_valid=1.
- m_valid  output  1  output buffer holds an unconsumed word.
- m_ready  input  1  consumer accepts m_data on a cycle where m_valid=1 and m_ready=1.
- frame_err  output  1  one-cycle pulse: stop bit sampled as '1'.
- overrun  output  1  one-cycle pulse: completed word dropped because the buffer was full.
- busy  output  1  high when the FSM is in DATA, STOP or HUNT.

Behaviour:
- Clocking and reset
  - One clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
  - rst_n=0, asserted at any time including mid-frame, immediately forces:
    - state=IDLE, bit counter=0, shift register=0
    - m_data=0, m_valid=0, frame_err=0, overrun=0, busy=0
  - Any partial frame is discarded. The first edge after release samples s_in in IDLE.
- FSM states: IDLE, DATA, STOP, HUNT.
  - IDLE: s_in=1 → DATA, counter=0. s_in=0 → stay in IDLE.
  - DATA: shift s_in into the LSB of the shift register (MSB-first reception). Counter increments.
    - When counter==WIDTH-1, this edge captures the last bit → STOP, counter=0.
  - STOP, s_in=0: frame good → word offered to the buffer → IDLE.
  - STOP, s_in=1: frame_err=1 for exactly one cycle, word discarded → HUNT.
  - HUNT: stay while s_in=1; s_in=0 → IDLE. This prevents a stuck-high line from being re-decoded as endless frames.
- Latency
  - Start bit sampled at edge 0; data bits at edges 1..WIDTH; stop bit at edge WIDTH+1.
  - m_valid/m_data update at edge WIDTH+1 (visible the following cycle).
- Back-to-back frames: a start bit may immediately follow a stop bit. The IDLE cycle consumes it, so there are no dead cycles.
- Output buffer, evaluated at each edge:
  - Accept: m_valid=1 and m_ready=1 consumes the held word.
  - New word arrives (good stop bit):
    - Buffer empty, or being consumed this same edge → load m_data, m_valid=1, no overrun.
    - m_valid=1 and m_ready=0 → keep old m_data, drop new word, overrun=1 for one cycle.
  - No new word and accept → m_valid=0. m_data holds its last value.
- frame_err and overrun are never simultaneously high.
- busy is combinational from state.
- Width rules: counter wraps only via explicit reset to 0 in STOP. No arithmetic beyond the counter increment.

Test Plan:
- Reset, then s_in=0 for 40 cycles, then s_in=1 permanently → start detected, data 0xFF, stop=1 → frame_err pulses once, FSM stays in HUNT, m_valid stays 0.
- m_ready=1. s_in stream 1,1,0,1,0,0,1,0,1,0 → m_data=0xA5 and m_valid=1 after the 10th edge. Accepted next cycle, after which m_valid=0.
- m_ready=0. Frames 0x3C then 0x81 back-to-back, no idle gap → m_data=0x3C, m_valid=1, overrun pulses at the second stop edge. m_data is still 0x3C afterwards.
- m_valid=1 holding 0x3C. m_ready=1 exactly on the edge where 0x81's stop bit is sampled → m_data=0x81, m_valid=1, overrun=0.
- rst_n pulsed low (asynchronous, mid-clock) after the 4th data bit of a frame → all outputs 0 immediately. The remaining bits of the aborted frame are ignored: they are treated as a new frame only if a '1' is seen in IDLE. A following clean 0x5A frame decodes correctly.
- Stop bit forced to 1 on frame 0x12, then s_in=0, then frame 0x34 → frame_err pulse, HUNT exits on the 0, then m_data=0x34.
